// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller: drives the reset and hold controls of the 5-stage core from B/J, load-use and external stall events.
// Outputs are Mealy (same-cycle). Define HAZ_PERF_CNT_EN to add saturating flush and stall-cycle counters.
module pipeline_hazard_controller #(
   parameter int FLUSH_CYCLES    = 1,
   parameter int LU_STALL_CYCLES = 1,
   parameter int NUM_STALL_SRC   = 2,
   parameter int PERF_CNT_WIDTH  = 32
) (
   input  logic                     CLK,
   input  logic                     RESET,
   input  logic                     BJ_SIG,
   input  logic                     LU_HAZ_SIG,
   input  logic [NUM_STALL_SRC-1:0] STALL_REQ,
   output logic                     PC_HOLD,
   output logic                     PR_IF_ID_RESET,
   output logic                     PR_IF_ID_HOLD,
   output logic                     PR_ID_EX_RESET,
   output logic                     PR_ID_EX_HOLD,
   output logic                     PR_EX_MEM_HOLD,
   output logic                     PR_MEM_WB_HOLD
`ifdef HAZ_PERF_CNT_EN
   ,
   output logic [PERF_CNT_WIDTH-1:0] FLUSH_COUNT,
   output logic [PERF_CNT_WIDTH-1:0] STALL_CYCLE_COUNT
`endif
);

   if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15 || LU_STALL_CYCLES < 1 || LU_STALL_CYCLES > 15 ||
       NUM_STALL_SRC < 1 || PERF_CNT_WIDTH < 1) begin : g_bad_params
      $error("pipeline_hazard_controller: parameter out of range");
   end

   typedef enum logic [1:0] {
      IDLE,
      FLUSH,
      LU_STALL
   } state_t;

   localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
   localparam logic [3:0] LU_LOAD    = 4'(LU_STALL_CYCLES - 1);

   state_t     state;
   state_t     state_nxt;
   logic [3:0] cnt;
   logic [3:0] cnt_nxt;
   logic       ext;

   assign ext = |STALL_REQ;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt;
      PC_HOLD        = 1'b0;
      PR_IF_ID_RESET = 1'b0;
      PR_IF_ID_HOLD  = 1'b0;
      PR_ID_EX_RESET = 1'b0;
      PR_ID_EX_HOLD  = 1'b0;
      PR_EX_MEM_HOLD = 1'b0;
      PR_MEM_WB_HOLD = 1'b0;
      if (!RESET) begin
         if (ext) begin
            // Freeze everything, including the sequencer, so an in-flight flush/stall resumes intact.
            PC_HOLD        = 1'b1;
            PR_IF_ID_HOLD  = 1'b1;
            PR_ID_EX_HOLD  = 1'b1;
            PR_EX_MEM_HOLD = 1'b1;
            PR_MEM_WB_HOLD = 1'b1;
         end else if (BJ_SIG) begin
            PR_IF_ID_RESET = 1'b1;
            PR_ID_EX_RESET = 1'b1;
            if (FLUSH_CYCLES > 1) begin
               state_nxt = FLUSH;
               cnt_nxt   = FLUSH_LOAD;
            end else begin
               state_nxt = IDLE;
               cnt_nxt   = 4'd0;
            end
         end else begin
            case (state)
               FLUSH: begin
                  PR_IF_ID_RESET = 1'b1;
                  PR_ID_EX_RESET = 1'b1;
                  if (cnt <= 4'd1) begin
                     state_nxt = IDLE;
                     cnt_nxt   = 4'd0;
                  end else begin
                     cnt_nxt = cnt - 4'd1;
                  end
               end
               LU_STALL: begin
                  PC_HOLD        = 1'b1;
                  PR_IF_ID_HOLD  = 1'b1;
                  PR_ID_EX_RESET = 1'b1;
                  if (cnt <= 4'd1) begin
                     state_nxt = IDLE;
                     cnt_nxt   = 4'd0;
                  end else begin
                     cnt_nxt = cnt - 4'd1;
                  end
               end
               default: begin
                  if (LU_HAZ_SIG) begin
                     PC_HOLD        = 1'b1;
                     PR_IF_ID_HOLD  = 1'b1;
                     PR_ID_EX_RESET = 1'b1;
                     if (LU_STALL_CYCLES > 1) begin
                        state_nxt = LU_STALL;
                        cnt_nxt   = LU_LOAD;
                     end
                  end
               end
            endcase
         end
      end
   end

`ifdef HAZ_PERF_CNT_EN
   logic bj_accept;

   assign bj_accept = BJ_SIG & ~ext;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         FLUSH_COUNT       <= '0;
         STALL_CYCLE_COUNT <= '0;
      end else begin
         if (bj_accept && FLUSH_COUNT != '1) begin
            FLUSH_COUNT <= FLUSH_COUNT + PERF_CNT_WIDTH'(1);
         end
         if (PC_HOLD && STALL_CYCLE_COUNT != '1) begin
            STALL_CYCLE_COUNT <= STALL_CYCLE_COUNT + PERF_CNT_WIDTH'(1);
         end
      end
   end
`endif

endmodule
